// File: rtl/modulo_controle_jogo.sv
// Naval-battle game sequencer: debounces the confirm button and walks CLEAR -> POSICIONAMENTO ->
// ATAQUE -> FIM, issuing single-cycle matrix strobes and tracking shots, hits and the outcome.
module modulo_controle_jogo #(
    parameter int DEB_CYCLES = 500000,
    parameter int SHOTS      = 15,
    localparam int SW        = $clog2(SHOTS + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          button_confirmation,
    input  logic [5:0]    hh2,
    input  logic          ship_at_coord,
    input  logic          atk_at_coord,
    input  logic [5:0]    target_hits,
    output logic [1:0]    phase,
    output logic          mat_clr,
    output logic          po_load,
    output logic          at_load,
    output logic [2:0]    at_row,
    output logic [2:0]    at_col,
    output logic [SW-1:0] shots_left,
    output logic [5:0]    hits,
    output logic          win,
    output logic          lose,
    output logic          err
);
    // state    | meaning
    // S_CLEAR  | one cycle: clear matrices, restore counters
    // S_POS    | wait for press to load ship preset
    // S_ATAQUE | each press is one attack attempt
    // S_FIM    | game over, win/lose held until press
    localparam logic [1:0] S_CLEAR  = 2'b00;
    localparam logic [1:0] S_POS    = 2'b01;
    localparam logic [1:0] S_ATAQUE = 2'b10;
    localparam logic [1:0] S_FIM    = 2'b11;

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          deb_level_q, deb_level_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic          press_q, press_d;

    logic [1:0]    state_q, state_d;
    logic [5:0]    tgt_q, tgt_d;
    logic [SW-1:0] shots_q, shots_d;
    logic [5:0]    hits_q, hits_d;
    logic          win_q, win_d, lose_q, lose_d;
    logic          mat_clr_q, mat_clr_d, po_load_q, po_load_d;
    logic          at_load_q, at_load_d, err_q, err_d;
    logic [2:0]    at_row_q, at_row_d, at_col_q, at_col_d;

    logic [2:0]    row, col;
    logic          bad_target;
    logic [5:0]    hits_inc;
    logic [SW-1:0] shots_dec;

    always_comb begin
        sync1_d     = button_confirmation;
        sync2_d     = sync1_q;
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        press_d     = 1'b0;
        // The DEB_CYCLES-th consecutive differing sample flips the level.
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == CW'(DEB_CYCLES - 1)) begin
                deb_level_d = sync2_q;
                press_d     = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign row        = hh2[5:3];
    assign col        = hh2[2:0];
    assign bad_target = (row > 3'd6) || (col > 3'd4) || atk_at_coord;
    assign hits_inc   = (ship_at_coord && hits_q != 6'd63) ? hits_q + 6'd1 : hits_q;
    assign shots_dec  = (shots_q != '0) ? shots_q - 1'b1 : shots_q;

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        shots_d   = shots_q;
        hits_d    = hits_q;
        win_d     = win_q;
        lose_d    = lose_q;
        at_row_d  = at_row_q;
        at_col_d  = at_col_q;
        mat_clr_d = 1'b0;
        po_load_d = 1'b0;
        at_load_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_CLEAR: begin
                state_d   = S_POS;
                mat_clr_d = 1'b1;
                shots_d   = SW'(SHOTS);
                hits_d    = '0;
                win_d     = 1'b0;
                lose_d    = 1'b0;
            end
            S_POS: begin
                if (press_q) begin
                    po_load_d = 1'b1;
                    tgt_d     = target_hits;
                    if (target_hits == 6'd0) begin
                        state_d = S_FIM;
                        win_d   = 1'b1;
                    end else begin
                        state_d = S_ATAQUE;
                    end
                end
            end
            S_ATAQUE: begin
                if (press_q) begin
                    if (bad_target) begin
                        err_d = 1'b1;
                    end else begin
                        at_load_d = 1'b1;
                        at_row_d  = row;
                        at_col_d  = col;
                        shots_d   = shots_dec;
                        hits_d    = hits_inc;
                        // A scoring last shot counts as a win, not a loss.
                        if (hits_inc == tgt_q) begin
                            state_d = S_FIM;
                            win_d   = 1'b1;
                        end else if (shots_dec == '0) begin
                            state_d = S_FIM;
                            lose_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (press_q) state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            press_q     <= 1'b0;
            state_q     <= S_CLEAR;
            tgt_q       <= '0;
            shots_q     <= SW'(SHOTS);
            hits_q      <= '0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            mat_clr_q   <= 1'b0;
            po_load_q   <= 1'b0;
            at_load_q   <= 1'b0;
            err_q       <= 1'b0;
            at_row_q    <= '0;
            at_col_q    <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            press_q     <= press_d;
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            shots_q     <= shots_d;
            hits_q      <= hits_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            mat_clr_q   <= mat_clr_d;
            po_load_q   <= po_load_d;
            at_load_q   <= at_load_d;
            err_q       <= err_d;
            at_row_q    <= at_row_d;
            at_col_q    <= at_col_d;
        end
    end

    assign phase      = state_q;
    assign mat_clr    = mat_clr_q;
    assign po_load    = po_load_q;
    assign at_load    = at_load_q;
    assign at_row     = at_row_q;
    assign at_col     = at_col_q;
    assign shots_left = shots_q;
    assign hits       = hits_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign err        = err_q;
endmodule

// File: tb/tb_modulo_controle_jogo.sv
// Bench for modulo_controle_jogo: directed game scenarios plus random presses, all checked
// against a per-press game model (phase, shots, hits, outcome, expected strobe and its latency).
module tb_modulo_controle_jogo;
    localparam int D     = 4;
    localparam int SHOTS = 3;
    localparam int SW    = $clog2(SHOTS + 1);

    logic          clk = 1'b0;
    logic          clr;
    logic          button_confirmation;
    logic [5:0]    hh2;
    logic          ship_at_coord, atk_at_coord;
    logic [5:0]    target_hits;
    logic [1:0]    phase;
    logic          mat_clr, po_load, at_load, win, lose, err;
    logic [2:0]    at_row, at_col;
    logic [SW-1:0] shots_left;
    logic [5:0]    hits;

    int n_chk = 0;
    int n_err = 0;

    // game model
    int m_ph, m_shots, m_hits, m_tgt;
    int m_win, m_lose;

    modulo_controle_jogo #(.DEB_CYCLES(D), .SHOTS(SHOTS)) dut (
        .clk(clk), .clr(clr), .button_confirmation(button_confirmation), .hh2(hh2),
        .ship_at_coord(ship_at_coord), .atk_at_coord(atk_at_coord), .target_hits(target_hits),
        .phase(phase), .mat_clr(mat_clr), .po_load(po_load), .at_load(at_load),
        .at_row(at_row), .at_col(at_col), .shots_left(shots_left), .hits(hits),
        .win(win), .lose(lose), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_phase"}, 32'(phase), m_ph);
        chk({tag, "_shots"}, 32'(shots_left), m_shots);
        chk({tag, "_hits"}, 32'(hits), m_hits);
        chk({tag, "_win"}, 32'(win), m_win);
        chk({tag, "_lose"}, 32'(lose), m_lose);
    endtask

    task automatic model_new_game();
        m_ph = 1; m_shots = SHOTS; m_hits = 0; m_win = 0; m_lose = 0;
    endtask

    task automatic do_press(input int hold, input logic [5:0] h, input logic ship,
                            input logic atk, input logic [5:0] tg);
        int n_mc, n_po, n_at, n_er, f_mc, f_po, f_at, f_er, multi;
        int e_mc, e_po, e_at, e_er, row, col;
        logic [2:0] rr, cc;
        n_mc = 0; n_po = 0; n_at = 0; n_er = 0; multi = 0;
        f_mc = -1; f_po = -1; f_at = -1; f_er = -1;
        e_mc = 0; e_po = 0; e_at = 0; e_er = 0;
        rr = '0; cc = '0;
        @(negedge clk);
        hh2 = h; ship_at_coord = ship; atk_at_coord = atk; target_hits = tg;
        button_confirmation = 1'b1;
        for (int c = 1; c <= hold + D + 6; c++) begin
            @(posedge clk); #1;
            if (mat_clr) begin n_mc++; if (f_mc < 0) f_mc = c; end
            if (po_load) begin n_po++; if (f_po < 0) f_po = c; end
            if (at_load) begin n_at++; if (f_at < 0) f_at = c; rr = at_row; cc = at_col; end
            if (err)     begin n_er++; if (f_er < 0) f_er = c; end
            if (int'(mat_clr) + int'(po_load) + int'(at_load) + int'(err) > 1) multi++;
            if (c == hold) button_confirmation = 1'b0;
        end
        row = int'(h[5:3]);
        col = int'(h[2:0]);
        if (hold >= D) begin
            case (m_ph)
                1: begin
                    e_po = 1;
                    m_tgt = int'(tg);
                    if (m_tgt == 0) begin m_ph = 3; m_win = 1; end
                    else m_ph = 2;
                end
                2: begin
                    if (row > 6 || col > 4 || atk) e_er = 1;
                    else begin
                        e_at = 1;
                        m_shots = m_shots - 1;
                        if (ship && m_hits < 63) m_hits = m_hits + 1;
                        if (m_hits == m_tgt) begin m_ph = 3; m_win = 1; end
                        else if (m_shots == 0) begin m_ph = 3; m_lose = 1; end
                    end
                end
                3: begin
                    e_mc = 1;
                    model_new_game();
                end
                default: ;
            endcase
        end
        chk("mat_clr_count", n_mc, e_mc);
        chk("po_load_count", n_po, e_po);
        chk("at_load_count", n_at, e_at);
        chk("err_count", n_er, e_er);
        chk("one_strobe", multi, 0);
        if (e_mc != 0) chk("mat_clr_latency", f_mc, D + 4);
        if (e_po != 0) chk("po_load_latency", f_po, D + 3);
        if (e_er != 0) chk("err_latency", f_er, D + 3);
        if (e_at != 0) begin
            chk("at_load_latency", f_at, D + 3);
            chk("at_row", 32'(rr), row);
            chk("at_col", 32'(cc), col);
        end
        chk_state("press");
    endtask

    // clr lands on the very edge where the debounced attack press would be acted on
    task automatic clr_on_attack(input logic [5:0] h);
        @(negedge clk);
        hh2 = h; ship_at_coord = 1'b1; atk_at_coord = 1'b0;
        button_confirmation = 1'b1;
        repeat (D + 2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        button_confirmation = 1'b0;
        @(posedge clk); #1;
        chk("clr_at_load", 32'(at_load), 0);
        chk("clr_err", 32'(err), 0);
        chk("clr_phase", 32'(phase), 0);
        chk("clr_shots", 32'(shots_left), SHOTS);
        chk("clr_hits", 32'(hits), 0);
        chk("clr_win_lose", {30'd0, win, lose}, 0);
        chk("clr_at_rowcol", {26'd0, at_row, at_col}, 0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        chk("clr_then_pos", 32'(phase), 1);
        chk("clr_then_mat_clr", 32'(mat_clr), 1);
        repeat (D + 4) @(posedge clk);
        #1;
        model_new_game();
        chk_state("after_clr");
    endtask

    initial begin
        clr = 1'b1; button_confirmation = 1'b0; hh2 = '0;
        ship_at_coord = 1'b0; atk_at_coord = 1'b0; target_hits = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phase", 32'(phase), 0);
        chk("rst_strobes", {28'd0, mat_clr, po_load, at_load, err}, 0);
        chk("rst_shots", 32'(shots_left), SHOTS);
        chk("rst_hits", 32'(hits), 0);
        chk("rst_win_lose", {30'd0, win, lose}, 0);
        chk("rst_at_rowcol", {26'd0, at_row, at_col}, 0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        chk("clear_to_pos", 32'(phase), 1);
        chk("clear_mat_clr", 32'(mat_clr), 1);
        @(posedge clk); #1;
        chk("mat_clr_one_cycle", 32'(mat_clr), 0);
        model_new_game();
        chk_state("start");

        do_press(3, 6'b000_000, 1'b0, 1'b0, 6'd2);            // glitch: no press
        do_press(40, 6'b000_000, 1'b0, 1'b0, 6'd2);           // long hold: one po_load
        chk("t2_phase", 32'(phase), 2);
        do_press(5, 6'b111_000, 1'b1, 1'b0, 6'd2);            // row 7 rejected
        chk("t3_shots", 32'(shots_left), 3);
        do_press(5, {3'd1, 3'd2}, 1'b1, 1'b0, 6'd2);
        do_press(6, {3'd3, 3'd4}, 1'b1, 1'b0, 6'd2);
        chk("t4_win", {30'd0, win, phase}, {30'd1, 2'b11});
        chk("t4_shots", 32'(shots_left), 1);
        do_press(4, 6'd0, 1'b0, 1'b0, 6'd2);                  // FIM -> new game
        do_press(4, 6'd0, 1'b0, 1'b0, 6'd2);
        do_press(4, {3'd2, 3'd1}, 1'b0, 1'b0, 6'd2);
        do_press(4, {3'd5, 3'd3}, 1'b0, 1'b0, 6'd2);
        do_press(4, {3'd6, 3'd4}, 1'b0, 1'b0, 6'd2);
        chk("t5_lose", {30'd0, lose, phase}, {30'd1, 2'b11});
        chk("t5_shots", 32'(shots_left), 0);
        do_press(4, 6'd0, 1'b0, 1'b0, 6'd2);
        chk("t5_restored", 32'(shots_left), 3);
        do_press(4, 6'd0, 1'b0, 1'b0, 6'd2);
        clr_on_attack({3'd4, 3'd3});

        for (int i = 0; i < 40; i++) begin
            if (m_ph == 2 && $urandom_range(0, 9) == 0) begin
                clr_on_attack(6'($urandom));
            end else begin
                do_press(int'($urandom_range(1, 7)), 6'($urandom),
                         1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                         6'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
